// File: rtl/command_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : command_issue_queue
// Description : FIFO-buffered issue stage for 12-bit ALU commands
//               ({op[2:0], addr1[2:0], addr2[2:0], addr3[2:0]}).
//               Commands are popped one at a time and presented to the
//               register-file controller. Each issue raises syscall for one
//               cycle, then holds the command stable for its execution
//               window. The stage then waits for ctrl_ready before it
//               issues the next command. CAS (op 3'b111) uses a longer window.
// Ports       : clk, rst_n (sync, active-low)
//               cmd_in/cmd_valid/cmd_ready  - host enqueue side
//               ctrl_ready                  - controller idle/ready
//               command/syscall             - registered issue outputs
//               busy, count, full, empty    - status
//               issued                      - wrapping count of issues
// Revision    : 1.0 - initial release
// ============================================================================
module command_issue_queue #(
  parameter int DEPTH    = 8,
  parameter int CMD_W    = 12,
  parameter int OP_HOLD  = 1,
  parameter int CAS_HOLD = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CMD_W-1:0]       cmd_in,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   ctrl_ready,
  output logic [CMD_W-1:0]       command,
  output logic                   syscall,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic [15:0]            issued
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int MAX_HOLD = (CAS_HOLD > OP_HOLD) ? CAS_HOLD : OP_HOLD;
  localparam int HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [2:0] OP_CAS = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    HOLD     = 2'd2,
    WAIT_RDY = 2'd3
  } state_t;

  // Storage is deliberately left without a reset; the pointers define validity.
  logic [CMD_W-1:0]  mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  state_t            state_q, state_d;
  logic [CMD_W-1:0]  command_q, command_d;
  logic              syscall_q, syscall_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [15:0]       issued_q, issued_d;

  logic              full_w;
  logic              empty_w;
  logic              push;
  logic              pop;

  // Status comes from the registered count only, so a pop in the same cycle
  // never opens a slot for a push while the queue is full.
  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);
  assign push    = cmd_valid && !full_w;

  // --------------------------------------------------------------------------
  // Issue FSM: next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    command_d  = command_q;
    syscall_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    issued_d   = issued_q;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        // The head is taken from the registered count, which means a push
        // into an empty queue is seen one cycle later. There is no bypass.
        if (!empty_w && ctrl_ready) begin
          pop       = 1'b1;
          command_d = mem_q[rd_ptr_q];
          syscall_d = 1'b1;
          state_d   = PULSE;
        end
      end
      PULSE: begin
        hold_cnt_d = (command_q[CMD_W-1 -: 3] == OP_CAS) ? HOLD_W'(CAS_HOLD)
                                                         : HOLD_W'(OP_HOLD);
        issued_d   = issued_q + 16'd1;
        state_d    = HOLD;
      end
      HOLD: begin
        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        if (hold_cnt_q == HOLD_W'(1)) begin
          state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (ctrl_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO pointer / occupancy next-state
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // DEPTH is a power of two, so the pointers wrap naturally.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      command_q  <= '0;
      syscall_q  <= 1'b0;
      hold_cnt_q <= '0;
      issued_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      command_q  <= command_d;
      syscall_q  <= syscall_d;
      hold_cnt_q <= hold_cnt_d;
      issued_q   <= issued_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign cmd_ready = !full_w;
  assign full      = full_w;
  assign empty     = empty_w;
  assign count     = count_q;
  assign command   = command_q;
  assign syscall   = syscall_q;
  assign busy      = (state_q != IDLE);
  assign issued    = issued_q;

endmodule
`default_nettype wire

// File: tb/tb_command_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_command_issue_queue
// Description : Self-checking bench for command_issue_queue. A transaction
//               model tracks the pending command list and the timing of each
//               command's execution window. Every DUT output is compared
//               with the model on each falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_command_issue_queue;

  localparam int DEPTH    = 8;
  localparam int CMD_W    = 12;
  localparam int OP_HOLD  = 1;
  localparam int CAS_HOLD = 3;

  logic                   clk;
  logic                   rst_n;
  logic [CMD_W-1:0]       cmd_in;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   ctrl_ready;
  logic [CMD_W-1:0]       command;
  logic                   syscall;
  logic                   busy;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;
  logic [15:0]            issued;

  command_issue_queue #(
    .DEPTH   (DEPTH),
    .CMD_W   (CMD_W),
    .OP_HOLD (OP_HOLD),
    .CAS_HOLD(CAS_HOLD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_in    (cmd_in),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .ctrl_ready(ctrl_ready),
    .command   (command),
    .syscall   (syscall),
    .busy      (busy),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .issued    (issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  //   m_q       : commands accepted but not yet issued
  //   m_window  : cycles left in the current command's execution window
  //               (the pulse cycle plus its hold cycles)
  //   m_await   : execution window finished, waiting for controller ready
  //   m_sys     : an issue happened at the last edge
  // --------------------------------------------------------------------------
  logic [CMD_W-1:0] m_q[$];
  int               m_window = 0;
  bit               m_await  = 1'b0;
  bit               m_sys    = 1'b0;
  logic [CMD_W-1:0] m_cmd    = '0;
  logic [15:0]      m_issued = '0;
  bit               prev_sys = 1'b0;

  task automatic model_step();
    bit sys_was;
    bit accept;
    if (!rst_n) begin
      m_q.delete();
      m_window = 0;
      m_await  = 1'b0;
      m_sys    = 1'b0;
      m_cmd    = '0;
      m_issued = '0;
      return;
    end
    sys_was = m_sys;
    m_sys   = 1'b0;
    // The issue count is incremented one cycle after the issue pulse.
    if (sys_was) m_issued = m_issued + 16'd1;
    accept = cmd_valid && (m_q.size() < DEPTH);
    if (m_window > 0) begin
      m_window--;
      if (m_window == 0) m_await = 1'b1;
    end else if (m_await) begin
      if (ctrl_ready) m_await = 1'b0;
    end else if (m_q.size() > 0 && ctrl_ready) begin
      m_cmd    = m_q.pop_front();
      m_sys    = 1'b1;
      m_window = 1 + ((m_cmd[11:9] == 3'b111) ? CAS_HOLD : OP_HOLD);
    end
    if (accept) m_q.push_back(cmd_in);
  endtask

  task automatic compare_all();
    check_eq("command",   32'(command),   32'(m_cmd));
    check_eq("syscall",   32'(syscall),   32'(m_sys));
    check_eq("busy",      32'(busy),      32'((m_window > 0) || m_await));
    check_eq("count",     32'(count),     32'(m_q.size()));
    check_eq("full",      32'(full),      32'(m_q.size() == DEPTH));
    check_eq("empty",     32'(empty),     32'(m_q.size() == 0));
    check_eq("cmd_ready", 32'(cmd_ready), 32'(m_q.size() < DEPTH));
    check_eq("issued",    32'(issued),    32'(m_issued));
    check_eq("no_b2b_syscall", 32'(syscall & prev_sys), 32'd0);
    prev_sys = syscall;
  endtask

  // One clock: the model advances on the rising edge using the inputs that
  // were held stable through it, and the outputs are compared on the
  // falling edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
    end
  endtask

  task automatic push(input logic [CMD_W-1:0] c);
    cmd_in    = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_in     = '0;
    cmd_valid  = 1'b0;
    ctrl_ready = 1'b0;

    // T1: reset held for two cycles
    tick(2);
    check_eq("t1_empty_after_reset", 32'(empty), 32'd1);
    check_eq("t1_ready_after_reset", 32'(cmd_ready), 32'd1);

    // T2: single non-CAS op; syscall appears two cycles after the push is presented
    rst_n      = 1'b1;
    ctrl_ready = 1'b1;
    push(12'h0D1);
    check_eq("t2_no_early_syscall", 32'(syscall), 32'd0);
    tick();
    check_eq("t2_syscall_latency", 32'(syscall), 32'd1);
    check_eq("t2_command", 32'(command), 32'h0D1);
    tick(6);
    check_eq("t2_issued", 32'(issued), 32'd1);

    // T3: CAS op holds longer
    push(12'hE53);
    tick(10);

    // T4: fill while controller is not ready; 9th push dropped
    ctrl_ready = 1'b0;
    for (int i = 1; i <= 9; i++) push(12'(i));
    check_eq("t4_full", 32'(full), 32'd1);
    check_eq("t4_cmd_ready_low", 32'(cmd_ready), 32'd0);
    ctrl_ready = 1'b1;
    tick(60);
    check_eq("t4_drained_empty", 32'(empty), 32'd1);

    // T5: stall in WAIT_RDY by holding ctrl_ready low after first issue
    push(12'h123);
    push(12'h456);
    ctrl_ready = 1'b0;
    tick(12);
    ctrl_ready = 1'b1;
    tick(12);

    // T6: reset during HOLD of a CAS with three entries queued
    push(12'hE01);
    push(12'h002);
    push(12'h003);
    push(12'h004);
    check_eq("t6_busy_before_reset", 32'(busy), 32'd1);
    check_eq("t6_count_before_reset", 32'(count), 32'd3);
    rst_n = 1'b0;
    tick();
    check_eq("t6_syscall_after_reset", 32'(syscall), 32'd0);
    check_eq("t6_count_after_reset", 32'(count), 32'd0);
    rst_n = 1'b1;
    tick(20);

    // Randomised traffic with CAS-biased opcodes and occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 299) != 0);
      cmd_valid  = ($urandom_range(0, 99) < 55);
      cmd_in     = 12'($urandom);
      if ($urandom_range(0, 3) == 0) cmd_in[11:9] = 3'b111;
      ctrl_ready = ($urandom_range(0, 99) < 70);
      tick();
    end
    cmd_valid  = 1'b0;
    rst_n      = 1'b1;
    ctrl_ready = 1'b1;
    tick(80);
    check_eq("final_drained_empty", 32'(empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
